// File: rtl/l2_line_responder_pkg.sv
// Shared types and line-geometry helpers for the L1 dcache / L2 responder interface.
// The helpers keep the cache and the responder in agreement on beat counts.
package l2_line_responder_pkg;

  typedef enum logic [1:0] {
    LOAD              = 2'd0,
    STORE             = 2'd1,
    LOAD_RESERVED     = 2'd2,
    STORE_CONDITIONAL = 2'd3
  } memory_operation_e;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } memory_operation_size_e;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT        = 3'd1,
    READ_BURST  = 3'd2,
    WRITE_BURST = 3'd3,
    DONE        = 3'd4
  } l2_responder_state_e;

  function automatic int words_per_line(input int line_size, input int xlen);
    return line_size / (xlen / 8);
  endfunction

  function automatic int word_select_size(input int line_size, input int xlen);
    return $clog2(words_per_line(line_size, xlen));
  endfunction

endpackage

// File: rtl/l2_backing_store.sv
// Single-port word-addressed RAM with a registered read port.
// Contents are never reset; only the read register clears so idle output is zero.
module l2_backing_store #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/l2_line_responder.sv
// Memory-side line responder: accepts one fill or writeback per transaction and
// streams or absorbs a full line against the backing store after a fixed latency.
module l2_line_responder
  import l2_line_responder_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int LINE_SIZE      = 32,
  parameter int OFS_SIZE       = 5,
  parameter int NUM_LINES      = 64,
  parameter int ACCESS_LATENCY = 4,
  localparam int WORDS_PER_LINE   = words_per_line(LINE_SIZE, XLEN),
  localparam int WORD_SELECT_SIZE = word_select_size(LINE_SIZE, XLEN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  memory_operation_e           req_type,
  input  logic [XLEN-OFS_SIZE-1:0]    req_block_address,
  input  logic                        wdata_valid,
  input  logic [XLEN-1:0]             wdata,
  output logic                        wdata_ready,
  output logic                        rdata_valid,
  output logic [XLEN-1:0]             rdata,
  output logic [WORD_SELECT_SIZE-1:0] rdata_word_index,
  output logic                        done
);

  localparam int LINE_IDX_SIZE = $clog2(NUM_LINES);
  localparam int ADDR_SIZE     = LINE_IDX_SIZE + WORD_SELECT_SIZE;
  localparam int LAT_SIZE      = (ACCESS_LATENCY > 0) ? $clog2(ACCESS_LATENCY + 1) : 1;
  localparam logic [WORD_SELECT_SIZE-1:0] LAST_BEAT = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);

  l2_responder_state_e         state, state_next;
  logic [LAT_SIZE-1:0]         lat_cnt, lat_next;
  logic [WORD_SELECT_SIZE-1:0] beat, beat_next;
  memory_operation_e           op, op_next;
  logic [LINE_IDX_SIZE-1:0]    line_idx, line_next;
  logic                        mem_we;
  logic                        mem_re;
  logic                        unused_addr_bits;

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
  // a writeback beat transfers with wdata_valid & wdata_ready; fill beats have no
  // backpressure and are qualified by rdata_valid alone.
  assign req_ready   = (state == IDLE);
  assign wdata_ready = (state == WRITE_BURST);
  assign mem_re      = (state == READ_BURST);

  // Upper address bits alias onto the same store line.
  assign unused_addr_bits = ^req_block_address[XLEN-OFS_SIZE-1:LINE_IDX_SIZE];

  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    beat_next  = beat;
    op_next    = op;
    line_next  = line_idx;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_next   = req_type;
          line_next = req_block_address[LINE_IDX_SIZE-1:0];
          beat_next = '0;
          if (ACCESS_LATENCY > 0) begin
            lat_next   = LAT_SIZE'(ACCESS_LATENCY);
            state_next = WAIT;
          end else begin
            state_next = (req_type == STORE) ? WRITE_BURST : READ_BURST;
          end
        end
      end
      WAIT: begin
        lat_next = lat_cnt - 1'b1;
        if (lat_cnt <= LAT_SIZE'(1)) begin
          state_next = (op == STORE) ? WRITE_BURST : READ_BURST;
        end
      end
      READ_BURST: begin
        beat_next = beat + 1'b1;
        if (beat == LAST_BEAT) begin
          state_next = DONE;
        end
      end
      WRITE_BURST: begin
        if (wdata_valid) begin
          mem_we    = !reset;
          beat_next = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fill outputs and done are registered one cycle behind the state that
  // produced them, lining them up with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      lat_cnt          <= '0;
      beat             <= '0;
      op               <= LOAD;
      line_idx         <= '0;
      rdata_valid      <= 1'b0;
      rdata_word_index <= '0;
      done             <= 1'b0;
    end else begin
      state            <= state_next;
      lat_cnt          <= lat_next;
      beat             <= beat_next;
      op               <= op_next;
      line_idx         <= line_next;
      rdata_valid      <= (state == READ_BURST);
      rdata_word_index <= (state == READ_BURST) ? beat : '0;
      done             <= (state == DONE);
    end
  end

  l2_backing_store #(
    .DATA_W (XLEN),
    .DEPTH  (NUM_LINES * WORDS_PER_LINE)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (ADDR_SIZE'({line_idx, beat})),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule
